// File: rtl/remora_pkg.sv
// Shared definitions for the remora joint-command path: supervisor state
// encoding, command width and default timing derived from the 48 MHz sysclk.
package remora_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ARMING = 2'd1,
      ST_RUN    = 2'd2,
      ST_FAULT  = 2'd3
   } sup_state_t;

   localparam int JOINT_CMD_W = 32;
   localparam int FRAME_CNT_W = 8;

   localparam int SYSCLK_HZ          = 48_000_000;
   localparam int DEF_TIMEOUT_CYCLES = SYSCLK_HZ / 10;    // 100 ms link loss
   localparam int DEF_ENABLE_STAGGER = SYSCLK_HZ / 1000;  // 1 ms per joint
   localparam int DEF_ARM_FRAMES     = 3;

endpackage

// File: rtl/watchdog_timer.sv
// Link watchdog: counts cycles since the last kick and flags expiry when the
// count sits at TIMEOUT_CYCLES-1 with no kick. A kick in the expiry cycle wins.
module watchdog_timer #(
   parameter int TIMEOUT_CYCLES = 4800000
) (
   input  logic clk,
   input  logic rst,
   input  logic enable,
   input  logic kick,
   output logic expired
);

   localparam int              CNT_W = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] count;

   // Held at zero while disabled; saturates at LAST so expiry stays asserted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                  count <= '0;
      else if (!enable || kick) count <= '0;
      else if (count != LAST)   count <= count + CNT_W'(1);
   end

   assign expired = enable && !kick && (count == LAST);

endmodule

// File: rtl/joint_cmd_supervisor.sv
// Gates joint commands/enables on link health: arm after ARM_FRAMES frames,
// release joint enables one at a time, and latch a fault on frame loss.
module joint_cmd_supervisor
   import remora_pkg::*;
#(
   parameter int NUM_JOINTS     = 5,
   parameter int TIMEOUT_CYCLES = 4800000,
   parameter int ARM_FRAMES     = 3,
   parameter int ENABLE_STAGGER = 48000
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              frame_valid,
   input  logic                              clear_fault,
   input  logic [JOINT_CMD_W*NUM_JOINTS-1:0] cmd_in,
   input  logic [NUM_JOINTS-1:0]             enable_in,
   output logic [JOINT_CMD_W*NUM_JOINTS-1:0] cmd_out,
   output logic [NUM_JOINTS-1:0]             enable_out,
   output logic                              fault,
   output logic [1:0]                        state
);

   localparam int CMD_W = JOINT_CMD_W * NUM_JOINTS;
   localparam int STG_W = $clog2(ENABLE_STAGGER + 1);
   localparam logic [STG_W-1:0]       STG_LAST = STG_W'(ENABLE_STAGGER - 1);
   localparam logic [FRAME_CNT_W-1:0] ARM_N    = FRAME_CNT_W'(ARM_FRAMES);
   localparam logic [FRAME_CNT_W-1:0] CNT_MAX  = '1;

   sup_state_t              state_q, state_n;
   logic [FRAME_CNT_W-1:0]  frame_cnt_q, frame_cnt_n, frame_inc;
   logic [CMD_W-1:0]        cmd_lat_q, cmd_lat_n, cmd_gated;
   logic [NUM_JOINTS-1:0]   stage_q, stage_n;
   logic [STG_W-1:0]        stag_cnt_q, stag_cnt_n;
   logic                    wd_enable, expired, run_n;

   assign wd_enable = (state_q == ST_ARMING) || (state_q == ST_RUN);

   watchdog_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdog (
      .clk     (clk),
      .rst     (rst),
      .enable  (wd_enable),
      .kick    (frame_valid),
      .expired (expired)
   );

   // Next-state logic: FSM, frame counter, command latch and stagger sequencer.
   always_comb begin
      state_n     = state_q;
      frame_cnt_n = frame_cnt_q;
      cmd_lat_n   = cmd_lat_q;
      stage_n     = stage_q;
      stag_cnt_n  = stag_cnt_q;
      frame_inc   = (frame_cnt_q == CNT_MAX) ? CNT_MAX : frame_cnt_q + FRAME_CNT_W'(1);
      case (state_q)
         ST_IDLE: begin
            frame_cnt_n = '0;
            cmd_lat_n   = '0;
            stage_n     = '0;
            stag_cnt_n  = '0;
            if (frame_valid) begin
               if (ARM_N == FRAME_CNT_W'(1)) begin
                  state_n   = ST_RUN;
                  cmd_lat_n = cmd_in;
                  stage_n   = NUM_JOINTS'(1);
               end else begin
                  state_n     = ST_ARMING;
                  frame_cnt_n = FRAME_CNT_W'(1);
               end
            end
         end
         ST_ARMING: begin
            if (expired) begin
               state_n = ST_FAULT;
            end else if (frame_valid) begin
               frame_cnt_n = frame_inc;
               if (frame_inc >= ARM_N) begin
                  state_n    = ST_RUN;
                  cmd_lat_n  = cmd_in;
                  stage_n    = NUM_JOINTS'(1);
                  stag_cnt_n = '0;
               end
            end
         end
         ST_RUN: begin
            if (expired) begin
               state_n    = ST_FAULT;
               cmd_lat_n  = '0;
               stage_n    = '0;
               stag_cnt_n = '0;
            end else begin
               if (frame_valid) cmd_lat_n = cmd_in;
               // Sequencer freezes once every joint has been released.
               if (!(&stage_q)) begin
                  if (stag_cnt_q == STG_LAST) begin
                     stage_n    = (stage_q << 1) | NUM_JOINTS'(1);
                     stag_cnt_n = '0;
                  end else begin
                     stag_cnt_n = stag_cnt_q + STG_W'(1);
                  end
               end
            end
         end
         ST_FAULT: begin
            frame_cnt_n = '0;
            cmd_lat_n   = '0;
            stage_n     = '0;
            stag_cnt_n  = '0;
            if (clear_fault) state_n = ST_IDLE;
         end
         default: state_n = ST_IDLE;
      endcase
   end

   assign run_n = (state_n == ST_RUN);

   // Joints not yet released by the stagger mask see a zero command.
   always_comb begin
      cmd_gated = '0;
      for (int i = 0; i < NUM_JOINTS; i++)
         if (stage_n[i]) cmd_gated[i*JOINT_CMD_W +: JOINT_CMD_W] = cmd_lat_n[i*JOINT_CMD_W +: JOINT_CMD_W];
   end

   // State and registered outputs; outputs reflect the post-edge state directly.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         frame_cnt_q <= '0;
         cmd_lat_q   <= '0;
         stage_q     <= '0;
         stag_cnt_q  <= '0;
         cmd_out     <= '0;
         enable_out  <= '0;
         fault       <= 1'b0;
      end else begin
         state_q     <= state_n;
         frame_cnt_q <= frame_cnt_n;
         cmd_lat_q   <= cmd_lat_n;
         stage_q     <= stage_n;
         stag_cnt_q  <= stag_cnt_n;
         cmd_out     <= run_n ? cmd_gated : '0;
         enable_out  <= run_n ? (enable_in & stage_n) : '0;
         fault       <= (state_n == ST_FAULT);
      end
   end

   assign state = state_q;

endmodule

// File: tb/tb_joint_cmd_supervisor.sv
// Scoreboard bench for joint_cmd_supervisor: a driver issues randomized
// frames/commands and pushes the reference model's expected outputs; a
// monitor pops and compares one entry per clock on the falling edge.
module tb_joint_cmd_supervisor;

   localparam int NJ  = 5;
   localparam int TO  = 100;
   localparam int ARM = 3;
   localparam int STG = 4;
   localparam int W   = NJ * 32;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          frame_valid = 1'b0;
   logic          clear_fault = 1'b0;
   logic [W-1:0]  cmd_in = '0;
   logic [NJ-1:0] enable_in = '0;
   logic [W-1:0]  cmd_out;
   logic [NJ-1:0] enable_out;
   logic          fault;
   logic [1:0]    state;

   always #5 clk = ~clk;

   joint_cmd_supervisor #(
      .NUM_JOINTS(NJ), .TIMEOUT_CYCLES(TO), .ARM_FRAMES(ARM), .ENABLE_STAGGER(STG)
   ) dut (
      .clk(clk), .rst(rst), .frame_valid(frame_valid), .clear_fault(clear_fault),
      .cmd_in(cmd_in), .enable_in(enable_in), .cmd_out(cmd_out),
      .enable_out(enable_out), .fault(fault), .state(state)
   );

   typedef struct {
      int            cyc;
      logic [1:0]    st;
      logic          flt;
      logic [NJ-1:0] en;
      logic [W-1:0]  cmd;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Reference model: mode, frames seen, cycle of last link activity,
   // cycle of RUN entry and the latest accepted command per joint.
   int               m_st, m_fcnt, m_last, m_entry;
   logic signed [31:0] m_lat [NJ];

   task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
      end
   endtask

   task automatic model_reset();
      m_st = 0; m_fcnt = 0; m_last = 0; m_entry = 0;
      for (int i = 0; i < NJ; i++) m_lat[i] = 0;
   endtask

   task automatic push_reset_exp(input int c);
      exp_t e;
      e.cyc = c; e.st = 2'd0; e.flt = 1'b0; e.en = '0; e.cmd = '0;
      sb.push_back(e);
   endtask

   task automatic model_step(input int c, input logic fv, input logic cf,
                             input logic [W-1:0] cmd, input logic [NJ-1:0] en);
      exp_t e;
      int   ns;
      case (m_st)
         0: if (fv) begin
               m_fcnt = 1; m_last = c;
               if (ARM == 1) begin
                  m_st = 2; m_entry = c;
                  for (int i = 0; i < NJ; i++) m_lat[i] = cmd[i*32 +: 32];
               end else m_st = 1;
            end
         1: if (fv) begin
               m_fcnt = (m_fcnt < 255) ? m_fcnt + 1 : 255;
               m_last = c;
               if (m_fcnt >= ARM) begin
                  m_st = 2; m_entry = c;
                  for (int i = 0; i < NJ; i++) m_lat[i] = cmd[i*32 +: 32];
               end
            end else if (c - m_last >= TO) m_st = 3;
         2: if (fv) begin
               m_last = c;
               for (int i = 0; i < NJ; i++) m_lat[i] = cmd[i*32 +: 32];
            end else if (c - m_last >= TO) begin
               m_st = 3;
               for (int i = 0; i < NJ; i++) m_lat[i] = 0;
            end
         default: if (cf) begin m_st = 0; m_fcnt = 0; end
      endcase
      e.cyc = c; e.st = 2'(m_st); e.flt = (m_st == 3); e.en = '0; e.cmd = '0;
      if (m_st == 2) begin
         ns = 1 + (c - m_entry) / STG;
         if (ns > NJ) ns = NJ;
         for (int i = 0; i < ns; i++) begin
            e.en[i] = en[i];
            e.cmd[i*32 +: 32] = m_lat[i];
         end
      end
      sb.push_back(e);
   endtask

   function automatic logic [W-1:0] rand_cmd();
      logic [W-1:0] r;
      for (int i = 0; i < NJ; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   task automatic step(input logic fv, input logic cf, input logic [W-1:0] cmd, input logic [NJ-1:0] en);
      frame_valid = fv; clear_fault = cf; cmd_in = cmd; enable_in = en;
      model_step(cyc + 1, fv, cf, cmd, en);
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n, input logic [NJ-1:0] en);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, rand_cmd(), en);
   endtask

   // Reset asserted between edges, after this cycle's outputs were checked.
   task automatic reset_mid();
      #5 rst = 1'b1;
      #2;
      chk("async_cmd_out", cmd_out, '0);
      chk("async_enable_out", W'(enable_out), '0);
      chk("async_fault", W'(fault), '0);
      chk("async_state", W'(state), '0);
      model_reset();
      frame_valid = 1'b0; clear_fault = 1'b0;
      push_reset_exp(cyc + 1);
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   // Monitor: compare every output against the entry tagged for this cycle.
   always @(negedge clk) begin
      exp_t e;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         e = sb.pop_front();
         chk("sb_order", W'(e.cyc), W'(cyc));
         chk("state", W'(state), W'(e.st));
         chk("fault", W'(fault), W'(e.flt));
         chk("enable_out", W'(enable_out), W'(e.en));
         chk("cmd_out", cmd_out, e.cmd);
      end
   end

   initial begin
      #500000;
      $display("FAIL sim_timeout cyc=%0d got=running want=finished", cyc);
      $fatal(1, "bench timeout");
   end

   initial begin
      logic [W-1:0] c;
      model_reset();
      for (int i = 0; i < 3; i++) begin
         push_reset_exp(cyc + 1);
         @(posedge clk); #1;
      end
      rst = 1'b0;
      idle(3, '1);

      // Arm and run with directed joint0/joint1 values, watch the stagger.
      c = rand_cmd();
      c[31:0]  = 32'sd1000;
      c[63:32] = -32'sd500;
      for (int f = 0; f < 3; f++) begin
         step(1'b1, 1'b0, c, '1);
         if (f < 2) idle(19, '1);
      end
      idle(25, '1);

      // Random RUN traffic, random enables, stray clear_fault pulses.
      for (int i = 0; i < 300; i++)
         step($urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0, rand_cmd(), NJ'($urandom));

      // Timeout from RUN.
      step(1'b1, 1'b0, rand_cmd(), '1);
      idle(105, '1);

      // Frames ignored in FAULT; clear with a coincident frame; re-arm.
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 1'b0, rand_cmd(), '1);
         idle(2, '1);
      end
      step(1'b1, 1'b1, rand_cmd(), '1);
      idle(3, '1);
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b0, rand_cmd(), '1);
         idle(4, '1);
      end
      idle(20, '1);

      // Kick-wins boundary, then a frame one cycle too late.
      step(1'b1, 1'b0, rand_cmd(), '1);
      idle(99, '1);
      step(1'b1, 1'b0, rand_cmd(), '1);
      idle(100, '1);
      step(1'b1, 1'b0, rand_cmd(), '1);
      idle(3, '1);
      step(1'b0, 1'b1, rand_cmd(), '1);
      idle(3, '1);

      // Async reset mid-RUN with joint2 carrying 7777.
      c = rand_cmd();
      c[95:64] = 32'd7777;
      for (int f = 0; f < 3; f++) begin
         step(1'b1, 1'b0, c, '1);
         idle(2, '1);
      end
      idle(12, '1);
      reset_mid();
      idle(3, '1);

      // Arming interrupted by link loss.
      step(1'b1, 1'b0, rand_cmd(), '1);
      idle(3, '1);
      step(1'b1, 1'b0, rand_cmd(), '1);
      idle(105, NJ'($urandom));
      step(1'b0, 1'b1, rand_cmd(), '1);
      idle(3, '1);

      @(negedge clk); #1;
      chk("sb_drained", W'(sb.size()), '0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/joint_cmd_supervisor.md
Name: joint_cmd_supervisor

Overview:
Sits between the SPI frame receiver and the stepgen/rcservo joint channels. It gates joint frequency commands and enables based on link health. It requires ARM_FRAMES consecutive valid frames before passing commands through, then staggers joint enables one joint at a time. If frames stop arriving for TIMEOUT_CYCLES it zeroes all commands and enables and latches a fault until the host clears it.

Parameters:
NUM_JOINTS, 5, number of joint channels supervised
TIMEOUT_CYCLES, 4800000, clk cycles without frame_valid before fault (100 ms at 48 MHz); must be >= 2
ARM_FRAMES, 3, consecutive valid frames required before RUN; 1..255
ENABLE_STAGGER, 48000, clk cycles between successive joint enable releases (1 ms); >= 1

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
frame_valid  in  1  one-cycle pulse when an rx frame with a valid header has been latched
clear_fault  in  1  one-cycle pulse; leaves FAULT
cmd_in  in  32*NUM_JOINTS  packed signed jointFreqCmd, joint 0 in bits [31:0]
enable_in  in  NUM_JOINTS  host-requested joint enables, bit i = joint i
cmd_out  out  32*NUM_JOINTS  gated commands to stepgens, same packing
enable_out  out  NUM_JOINTS  gated joint enables
fault  out  1  high while in FAULT
state  out  2  current state encoding (IDLE=0, ARMING=1, RUN=2, FAULT=3)

Behaviour:
- Reset (async assert, sync release): state=IDLE, cmd_out=0, enable_out=0, fault=0. Watchdog, frame counter and stagger counters cleared.
- All outputs are registered. cmd_out updates 1 cycle after the qualifying frame_valid.
- Watchdog: a counter clears on frame_valid and otherwise increments, saturating. Expiry is the cycle the count reaches TIMEOUT_CYCLES-1 with no frame_valid. frame_valid in the same cycle as expiry wins, so no expiry occurs. The watchdog is active in ARMING and RUN only, and is held at 0 in IDLE and FAULT.
- IDLE: outputs zero. frame_valid -> ARMING with frame_count=1. If ARM_FRAMES==1, go straight to RUN instead.
- ARMING: cmd_out=0, enable_out=0. Each frame_valid increments frame_count, saturating at 255. When frame_count reaches ARM_FRAMES -> RUN; cmd_in is latched into cmd_out on that same frame. Expiry -> FAULT.
- RUN:
  - Each frame_valid latches cmd_in into cmd_out. cmd_out holds between frames.
  - Stagger mask stage[NUM_JOINTS-1:0] is cleared on RUN entry. stage[0] is set on the entry cycle.
  - Each further ENABLE_STAGGER cycles sets the next bit, up to all ones; the counter then stops.
  - enable_out = enable_in & stage, registered.
  - A joint with stage[i]=0 has cmd_out slice forced to 0, regardless of the latched value. When stage[i] sets, the latched value appears on the next cycle.
  - Expiry -> FAULT.
- FAULT: cmd_out=0, enable_out=0, fault=1. frame_valid is ignored and the latched cmd is cleared. clear_fault -> IDLE. clear_fault together with frame_valid -> IDLE, and the frame is not counted.
- clear_fault outside FAULT: no effect.
- rst asserted mid-RUN: all outputs zero immediately (async). After release, re-arming requires ARM_FRAMES fresh frames.
- Negative commands pass through unchanged. No arithmetic is applied to cmd values.

Decomposition:
- Shared package (remora_pkg):
  - state encoding constants: ST_IDLE, ST_ARMING, ST_RUN, ST_FAULT
  - JOINT_CMD_W=32
  - default timing constants derived from the 48 MHz sysclk
- One natural sub-module: watchdog_timer.
  - Parameter: TIMEOUT_CYCLES.
  - Ports: clk, rst, enable, kick, expired.
  - Saturating counter with the kick-wins rule.
- The supervisor FSM, frame counter, stagger sequencer and output gating stay in joint_cmd_supervisor.

Test Plan:
Bench parameters: NUM_JOINTS=5, TIMEOUT_CYCLES=100, ARM_FRAMES=3, ENABLE_STAGGER=4.
1. Arm and run: three frame_valid pulses 20 cycles apart, with cmd_in joint0=1000 and joint1=-500 and enable_in=5'b11111 -> state=ARMING after frame 1 and RUN after frame 3. cmd_out and enable_out stay 0 until RUN. enable_out is 00001 on RUN entry, then 00011, 00111, 01111, 11111 at 4-cycle steps. joint1 cmd_out=-500 appears only once enable bit 1 is set.
2. Timeout: in RUN, stop frames -> on cycle 100 after the last frame, state=FAULT, fault=1, cmd_out=0, enable_out=0.
3. Kick-wins boundary: in RUN, pulse frame_valid exactly at count 99 -> no FAULT, watchdog restarts; pulse at cycle 101 -> FAULT already asserted.
4. Fault recovery: in FAULT, send 5 frames -> state stays FAULT. Then clear_fault together with frame_valid -> IDLE, frame_count=0. Three more frames -> RUN.
5. Async reset mid-RUN: with cmd_out joint2=7777, assert rst between clock edges -> all outputs 0 before the next edge. After release, state=IDLE.
6. Arming interrupted: two frames, then a 100-cycle gap -> FAULT reached from ARMING, and enable_out never went nonzero.
